vga_draw_arbiter: RTL

Shares the single VGA framebuffer pixel-write port between several draw requesters: screen clear, homebase, rocket movement, aliens and bullets. Each requester asks for a solid rectangle in one colour. The block grants requesters in round-robin order and sweeps the granted rectangle one pixel per clock onto the plot port. It sits between the game control FSMs and the VGA adapter and replaces their direct writes to the adapter.

---
 rtl/vga_draw_pkg.sv | 23 ++
 rtl/vga_draw_arbiter_rr_pick.sv | 27 ++
 rtl/vga_draw_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vga_draw_pkg.sv
// rtl/vga_draw_pkg.sv - shared constants, state encoding and requester indices for the draw arbiter.
package vga_draw_pkg;

  localparam int H_RES = 160;
  localparam int V_RES = 120;

  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_COLOR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int REQ_CLEAR    = 0;
  localparam int REQ_HOMEBASE = 1;
  localparam int REQ_ROCKET   = 2;
  localparam int REQ_SPRITE   = 3;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// rtl/vga_draw_arbiter_rr_pick.sv - combinational round-robin select, searching upward from ptr+1 with wrap.
module draw_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      winner,
  output logic               valid
);

  logic [IW-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin rectangle-fill arbiter driving the VGA plot port.
// Optional DRAW_ARB_CLIP_EN suppresses plots outside H_RES x V_RES instead of wrapping.
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*X_W-1:0]     rect_x,
  input  logic [NUM_REQ*Y_W-1:0]     rect_y,
  input  logic [NUM_REQ*X_W-1:0]     rect_w,
  input  logic [NUM_REQ*Y_W-1:0]     rect_h,
  input  logic [NUM_REQ*COLOR_W-1:0] rect_colour,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COLOR_W-1:0]         vga_colour,
  output logic                       vga_plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, owner_q, owner_d;
  logic [X_W-1:0]       bx_q, bx_d, bw_q, bw_d, cx_q, cx_d;
  logic [Y_W-1:0]       by_q, by_d, bh_q, bh_d, cy_q, cy_d;
  logic [COLOR_W-1:0]   bc_q, bc_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic                 busy_q, busy_d, plot_q, plot_d;
  logic [X_W-1:0]       vga_x_q, vga_x_d;
  logic [Y_W-1:0]       vga_y_q, vga_y_d;
  logic [COLOR_W-1:0]   vga_colour_q, vga_colour_d;

  logic [IW-1:0]        pick_winner;
  logic                 pick_valid;
  logic                 size_ok, col_end, last_px, draw_px, in_bounds;
  logic [X_W-1:0]       nx, px_sel;
  logic [Y_W-1:0]       ny, py_sel;
  logic [NUM_REQ-1:0]   pick_1h, owner_1h;

  draw_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign size_ok  = (bw_q != '0) && (bh_q != '0);
  assign col_end  = (cx_q == bw_q - X_W'(1));
  assign last_px  = col_end && (cy_q == bh_q - Y_W'(1));
  assign nx       = col_end ? '0 : cx_q + X_W'(1);
  assign ny       = col_end ? cy_q + Y_W'(1) : cy_q;
  // Outputs are registered, so each cycle computes the pixel shown next cycle.
  assign px_sel   = (state_q == GRANT) ? '0 : nx;
  assign py_sel   = (state_q == GRANT) ? '0 : ny;
  assign pick_1h  = NUM_REQ'(1) << pick_winner;
  assign owner_1h = NUM_REQ'(1) << owner_q;

`ifdef DRAW_ARB_CLIP_EN
  logic [X_W:0] ux;
  logic [Y_W:0] uy;
  assign ux        = {1'b0, bx_q} + {1'b0, px_sel};
  assign uy        = {1'b0, by_q} + {1'b0, py_sel};
  assign in_bounds = (ux < (X_W+1)'(H_RES)) && (uy < (Y_W+1)'(V_RES));
`else
  assign in_bounds = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= IW'(NUM_REQ - 1);
      owner_q      <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      bw_q         <= '0;
      bh_q         <= '0;
      bc_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      plot_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      bw_q         <= bw_d;
      bh_q         <= bh_d;
      bc_q         <= bc_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      plot_q       <= plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   state_d = size_ok ? DRAW : DONE;
      DRAW:    if (last_px) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    bx_d         = bx_q;
    by_d         = by_q;
    bw_d         = bw_q;
    bh_d         = bh_q;
    bc_d         = bc_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    grant_d      = '0;
    done_d       = '0;
    draw_px      = 1'b0;
    busy_d       = (state_d != IDLE);
    plot_d       = 1'b0;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          ptr_d   = pick_winner;
          owner_d = pick_winner;
          bx_d    = rect_x[pick_winner*X_W +: X_W];
          by_d    = rect_y[pick_winner*Y_W +: Y_W];
          bw_d    = rect_w[pick_winner*X_W +: X_W];
          bh_d    = rect_h[pick_winner*Y_W +: Y_W];
          bc_d    = rect_colour[pick_winner*COLOR_W +: COLOR_W];
          grant_d = pick_1h;
        end
      end
      GRANT: begin
        cx_d = '0;
        cy_d = '0;
        if (size_ok) begin
          grant_d = grant_q;
          draw_px = 1'b1;
        end else begin
          done_d = owner_1h;
        end
      end
      DRAW: begin
        if (last_px) begin
          done_d = owner_1h;
        end else begin
          grant_d = grant_q;
          cx_d    = nx;
          cy_d    = ny;
          draw_px = 1'b1;
        end
      end
      default: ;
    endcase
    if (draw_px) begin
      vga_x_d      = bx_q + px_sel;
      vga_y_d      = by_q + py_sel;
      vga_colour_d = bc_q;
      plot_d       = in_bounds;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = plot_q;

endmodule
